uart_receiver_ash: RTL and testbench

- UART receive stage: deserialises the frame produced by the team's UART transmitter and delivers the byte with status flags.
- Frame format: start bit (0), 8 data bits LSB first, even parity bit (XOR of the data), stop bit (1).
- Sits directly downstream of the transmitter's TXD line, loopback or across a link.
- Bit time is CLKS_PER_BIT clocks. CLKS_PER_BIT=1 matches the transmitter's one-bit-per-clock signalling.

---
 rtl/uart_receiver_ash_if.sv | 13 +
 rtl/uart_receiver_ash.sv | 129 ++++++++++++
 tb/tb_uart_receiver_ash.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_receiver_ash_if.sv
// Receiver-side signal bundle: serial line in, received byte and status out.
// master = receiver, slave = line driver / consumer.
interface uart_receiver_ash_if;
  logic       RXD;
  logic [7:0] RX_Data;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  modport master (input RXD, output RX_Data, data_valid, parity_error, framing_error, busy);
  modport slave  (output RXD, input RX_Data, data_valid, parity_error, framing_error, busy);
endinterface

// File: rtl/uart_receiver_ash.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop.
// Samples once per bit at the mid-point found from the start-bit edge.
module uart_receiver_ash #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_receiver_ash_if.master  rx
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, r_data;
  logic          r_par, r_dv, r_pe, r_fe;
  logic          w_rx_s, w_bit_done, w_shift_en, w_par_en, w_stop_en;

  assign w_rx_s     = r_sync[1];
  assign w_bit_done = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_idx_nxt  = r_idx;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_stop_en  = 1'b0;
    case (r_state)
      S_IDLE: if (!w_rx_s) begin
        // With HALF==0 the first low cycle is itself the start sample.
        if (HALF == 0) begin
          w_next    = S_DATA;
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
        end else begin
          w_next    = S_START;
          w_cnt_nxt = CW'(1);
        end
      end
      S_START: begin
        if (r_cnt == HALF_C) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          w_next    = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_shift_en = 1'b1;
          w_cnt_nxt  = '0;
          if (r_idx == 3'd7) w_next = S_PARITY;
          else               w_idx_nxt = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_done) begin
          w_par_en  = 1'b1;
          w_cnt_nxt = '0;
          w_next    = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_stop_en = 1'b1;
          w_cnt_nxt = '0;
          w_next    = w_rx_s ? S_IDLE : S_RECOVER;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RECOVER: if (w_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Synchroniser resets high so releasing reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx.RXD};
      r_dv   <= w_stop_en;
      if (w_shift_en) r_shift[r_idx] <= w_rx_s;
      if (w_par_en)   r_par <= w_rx_s;
      if (w_stop_en) begin
        r_data <= r_shift;
        r_pe   <= (^r_shift) ^ r_par;
        r_fe   <= ~w_rx_s;
      end
    end
  end

  assign rx.RX_Data       = r_data;
  assign rx.data_valid    = r_dv;
  assign rx.parity_error  = r_pe;
  assign rx.framing_error = r_fe;
  assign rx.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_receiver_ash.sv
// Directed bench: one receiver at 1 clk/bit (loopback timing), one at 16 clk/bit.
module tb_uart_receiver_ash;
  logic clk = 1'b0;
  logic reset;
  logic rxd_l, rxd_o;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  uart_receiver_ash_if if_l ();
  uart_receiver_ash_if if_o ();
  assign if_l.RXD = rxd_l;
  assign if_o.RXD = rxd_o;

  uart_receiver_ash #(.CLKS_PER_BIT(1))  u_l (.clk(clk), .reset(reset), .rx(if_l.master));
  uart_receiver_ash #(.CLKS_PER_BIT(16)) u_o (.clk(clk), .reset(reset), .rx(if_o.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors: count data_valid pulses and capture the cycle and payload.
  int         nl = 0, no = 0, tl = -1, to = -1;
  logic [7:0] dl, dO;
  logic       pel, fel, peo, feo;
  logic       bl_hist [0:255];
  always @(negedge clk) begin
    if (cyc < 256) bl_hist[cyc] = if_l.busy;
    if (if_l.data_valid) begin
      nl++; tl = cyc; dl = if_l.RX_Data; pel = if_l.parity_error; fel = if_l.framing_error;
    end
    if (if_o.data_valid) begin
      no++; to = cyc; dO = if_o.RX_Data; peo = if_o.parity_error; feo = if_o.framing_error;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; tstart is the cycle in which the start bit first appears.
  task automatic send(input bit sel, input logic [7:0] d, input logic par,
                      input logic stp, output int tstart);
    logic [10:0] fr;
    int cpb;
    fr  = {stp, par, d, 1'b0};
    cpb = sel ? 16 : 1;
    @(posedge clk); #1;
    tstart = cyc;
    for (int i = 0; i < 11; i++) begin
      if (sel) rxd_o = fr[i]; else rxd_l = fr[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t, base;
    reset = 1'b1; rxd_l = 1'b1; rxd_o = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {24'd0, if_o.RX_Data}, 32'h0);
    chk("rst_flags", {if_o.data_valid, if_o.parity_error, if_o.framing_error, if_o.busy}, 4'h0);
    chk("rst_flags_l", {if_l.data_valid, if_l.parity_error, if_l.framing_error, if_l.busy}, 4'h0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (4) @(posedge clk);

    // Loopback timing, 1 clk per bit.
    send(1'b0, 8'hA5, 1'b0, 1'b1, t);
    repeat (10) @(posedge clk);
    #1;
    chk("lb_count", nl, 1);
    chk("lb_cycle", tl, t + 13);
    chk("lb_data", {24'd0, dl}, 32'hA5);
    chk("lb_errs", {pel, fel}, 2'b00);
    for (int k = t + 1; k <= t + 14; k++)
      chk($sformatf("lb_busy_%0d", k - t), bl_hist[k], (k >= t + 3 && k <= t + 12));

    // Oversampled, clean byte.
    send(1'b1, 8'h3C, 1'b0, 1'b1, t);
    repeat (20) @(posedge clk);
    #1;
    chk("os_count", no, 1);
    chk("os_cycle", to, t + 170);
    chk("os_data", {24'd0, dO}, 32'h3C);
    chk("os_errs", {peo, feo}, 2'b00);
    chk("os_busy", if_o.busy, 1'b0);

    // Parity fault: 0x01 needs parity 1, send 0.
    send(1'b1, 8'h01, 1'b0, 1'b1, t);
    repeat (20) @(posedge clk);
    #1;
    chk("par_count", no, 2);
    chk("par_data", {24'd0, dO}, 32'h01);
    chk("par_errs", {peo, feo}, 2'b10);

    // Framing fault followed by a long break.
    send(1'b1, 8'hFF, 1'b0, 1'b0, t);
    repeat (40 * 16) @(posedge clk);
    #1;
    chk("brk_count", no, 3);
    chk("brk_data", {24'd0, dO}, 32'hFF);
    chk("brk_errs", {peo, feo}, 2'b01);
    chk("brk_busy_low", if_o.busy, 1'b1);
    rxd_o = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("brk_count_after", no, 3);
    chk("brk_busy_idle", if_o.busy, 1'b0);

    // Glitch: 4 low clocks, shorter than half a bit.
    @(posedge clk); #1;
    t = cyc;
    rxd_o = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd_o = 1'b1;
    @(negedge clk);
    chk("gl_busy_mid", if_o.busy, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("gl_count", no, 3);
    chk("gl_busy_idle", if_o.busy, 1'b0);

    // Reset during data bit 3 of 0x55, then a clean 0x81.
    @(posedge clk); #1;
    base = no;
    rxd_o = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1; rxd_o = logic'((8'h55 >> i) & 8'h1);
      repeat ((i == 3) ? 8 : 16) @(posedge clk);
    end
    #1; reset = 1'b1;
    @(negedge clk);
    chk("mr_data", {24'd0, if_o.RX_Data}, 32'h0);
    chk("mr_flags", {if_o.data_valid, if_o.parity_error, if_o.framing_error, if_o.busy}, 4'h0);
    @(posedge clk); #1;
    rxd_o = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("mr_no_pulse", no, base);
    send(1'b1, 8'h81, 1'b0, 1'b1, t);
    repeat (20) @(posedge clk);
    #1;
    chk("mr_count", no, base + 1);
    chk("mr_cycle", to, t + 170);
    chk("mr_data2", {24'd0, dO}, 32'h81);
    chk("mr_errs", {peo, feo}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
